hsv_core_issue: RTL

- Issue stage, directly downstream of decode; consumes the issue_data_t stream from the decode skid buffer.
- Tracks in-flight destination registers in a scoreboard, stalls on RAW/WAW hazards, and reads rs1/rs2 from the register file with writeback bypass.
- Dispatches each instruction to exactly one execution unit (alu, foo, mem, branch, ctrlstatus) through a registered one-entry output stage.

---
 rtl/hsv_core_issue.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/hsv_core_issue.sv
// Issue stage: scoreboard hazard check, operand read with writeback
// bypass, and a one-entry registered dispatch slot per execution unit.
package hsv_core_issue_pkg;
  typedef struct packed {
    logic [4:0] rs1_addr;
    logic [4:0] rs2_addr;
    logic [4:0] rd_addr;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       writes_rd;
  } issue_common_t;

  // exec_select bit order: alu, foo, mem, branch, ctrlstatus
  typedef struct packed {
    issue_common_t common;
    logic [4:0]    exec_select;
    logic [31:0]   imm;
  } issue_data_t;

  localparam int unsigned SEL_ALU = 0;
  localparam int unsigned SEL_FOO = 1;
  localparam int unsigned SEL_MEM = 2;
  localparam int unsigned SEL_BR  = 3;
  localparam int unsigned SEL_CSR = 4;
endpackage

module hsv_core_issue
  import hsv_core_issue_pkg::*;
#(
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk_core,
  input  logic                  rst_core,
  input  logic                  flush_req,
  output logic                  flush_ack,
  output logic                  ready_o,
  input  logic                  valid_i,
  input  issue_data_t           issue_data,
  output logic [REG_ADDR_W-1:0] rf_raddr1,
  output logic [REG_ADDR_W-1:0] rf_raddr2,
  input  logic [31:0]           rf_rdata1,
  input  logic [31:0]           rf_rdata2,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [31:0]           wb_data,
  output issue_data_t           exec_data,
  output logic [31:0]           rs1_value,
  output logic [31:0]           rs2_value,
  output logic                  alu_valid_o,
  output logic                  foo_valid_o,
  output logic                  mem_valid_o,
  output logic                  branch_valid_o,
  output logic                  ctrlstatus_valid_o,
  input  logic                  alu_ready_i,
  input  logic                  foo_ready_i,
  input  logic                  mem_ready_i,
  input  logic                  branch_ready_i,
  input  logic                  ctrlstatus_ready_i
);

  logic [REG_COUNT-1:0] pending_q, pending_d;
  logic [REG_COUNT-1:0] wb_mask, eff;
  logic [4:0]           valid_q, valid_d;
  logic [4:0]           unit_ready;
  logic                 flush_ack_q;
  issue_data_t          exec_data_q, exec_data_d;
  logic [31:0]          rs1_q, rs1_d;
  logic [31:0]          rs2_q, rs2_d;
  logic                 hazard, out_busy, fire;

  function automatic logic [31:0] pick(
    input logic [REG_ADDR_W-1:0] addr,
    input logic [31:0]           rdata
  );
    if (addr == '0) return 32'd0;
    if (wb_valid && wb_rd == addr) return wb_data;
    return rdata;
  endfunction

  assign rf_raddr1 = issue_data.common.rs1_addr;
  assign rf_raddr2 = issue_data.common.rs2_addr;

  assign unit_ready = {ctrlstatus_ready_i, branch_ready_i,
                       mem_ready_i, foo_ready_i, alu_ready_i};

  always_comb begin
    wb_mask = '0;
    if (wb_valid && wb_rd != '0) wb_mask[wb_rd] = 1'b1;
    eff = pending_q & ~wb_mask;
    hazard = valid_i & (
      (issue_data.common.uses_rs1  & eff[issue_data.common.rs1_addr]) |
      (issue_data.common.uses_rs2  & eff[issue_data.common.rs2_addr]) |
      (issue_data.common.writes_rd & eff[issue_data.common.rd_addr]));
    out_busy = |(valid_q & ~unit_ready);
    ready_o  = ~hazard & ~out_busy & ~flush_req;
    fire     = valid_i & ready_o;
  end

  always_comb begin
    pending_d   = eff;
    valid_d     = valid_q & ~unit_ready;
    exec_data_d = exec_data_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    if (fire) begin
      valid_d     = issue_data.exec_select;
      exec_data_d = issue_data;
      rs1_d       = pick(issue_data.common.rs1_addr, rf_rdata1);
      rs2_d       = pick(issue_data.common.rs2_addr, rf_rdata2);
      // set after clear so a same-edge writeback cannot drop it
      if (issue_data.common.writes_rd &&
          issue_data.common.rd_addr != '0)
        pending_d[issue_data.common.rd_addr] = 1'b1;
    end
    if (flush_req) begin
      pending_d = '0;
      valid_d   = '0;
    end
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      pending_q   <= '0;
      valid_q     <= '0;
      flush_ack_q <= 1'b1;
    end else begin
      pending_q   <= pending_d;
      valid_q     <= valid_d;
      flush_ack_q <= flush_req;
    end
  end

  always_ff @(posedge clk_core) begin
    exec_data_q <= exec_data_d;
    rs1_q       <= rs1_d;
    rs2_q       <= rs2_d;
  end

  assign flush_ack          = flush_ack_q;
  assign exec_data          = exec_data_q;
  assign rs1_value          = rs1_q;
  assign rs2_value          = rs2_q;
  assign alu_valid_o        = valid_q[SEL_ALU];
  assign foo_valid_o        = valid_q[SEL_FOO];
  assign mem_valid_o        = valid_q[SEL_MEM];
  assign branch_valid_o     = valid_q[SEL_BR];
  assign ctrlstatus_valid_o = valid_q[SEL_CSR];

  a_sel_onehot: assert property (@(posedge clk_core)
    disable iff (rst_core) fire |-> $onehot(issue_data.exec_select));

endmodule
